pc_fetch_gen: RTL
=================

PC_FETCH_GEN -- requirements
Module: pc_fetch_gen

Interface
REQ-001 The block SHALL have parameter RESET_VECTOR, default 32'h0000_0000, giving the PC loaded on reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port pc_out, output, 32 bits: current PC, driven to the PC+4 adder in_1 and to instruction memory.
REQ-005 The block SHALL have port pc_plus4_in, input, 32 bits: the adder sum_out (adder in_2 tied to 32'd4 externally).
REQ-006 The block SHALL have port fetch_valid, output, 1 bit: pc_out holds a fetch request for decode.
REQ-007 The block SHALL have port fetch_ready, input, 1 bit: decode accepts the current fetch.
REQ-008 The block SHALL have port stall, input, 1 bit: hazard hold request from the pipeline.
REQ-009 The block SHALL have ports redirect_valid (input, 1 bit) and redirect_target (input, 32 bits): branch/jump redirect request and target.
REQ-010 The block SHALL have port fetch_count, output, 32 bits: number of completed fetch handshakes.
REQ-011 The block SHALL have ports misalign_err (output, 1 bit) and err_clear (input, 1 bit): trap flag and clear (see Configuration).

Function
REQ-012 The block SHALL implement states IDLE, RUN, HOLD, plus TRAP when PC_MISALIGN_TRAP_EN is defined.
REQ-013 The block SHALL assert fetch_valid only in RUN; fetch_valid SHALL be registered, not combinational from inputs.
REQ-014 A fetch handshake SHALL occur on a cycle with fetch_valid=1 and fetch_ready=1.
REQ-015 IDLE SHALL transition to RUN unconditionally on the first cycle after reset deasserts.
REQ-016 In RUN, on handshake with stall=0 and redirect_valid=0, pc_out SHALL load pc_plus4_in on the next edge.
REQ-017 In RUN with fetch_ready=0, pc_out and fetch_valid SHALL remain stable.
REQ-018 On stall=1 and redirect_valid=0 in RUN, the block SHALL enter HOLD next cycle with pc_out unchanged, even if a handshake occurs that cycle.
REQ-019 In HOLD, the block SHALL return to RUN on the first cycle stall=0, pc_out unchanged.
REQ-020 Priority SHALL be rst > redirect_valid > stall > handshake advance.
REQ-021 redirect_valid=1 in RUN or HOLD SHALL load pc_out from the target next edge; next state HOLD if stall=1, else RUN.
REQ-022 redirect_valid in IDLE SHALL be ignored.
REQ-023 fetch_count SHALL increment by 1 per handshake, wrap 32'hFFFF_FFFF -> 0, and count the handshake even when redirect or stall is asserted that cycle.
REQ-024 pc_out wrap-around SHALL follow pc_plus4_in unmodified (32'hFFFF_FFFC -> 32'h0).

Reset
REQ-025 While rst=1 at a clock edge, the block SHALL set pc_out=RESET_VECTOR, fetch_valid=0, fetch_count=0, misalign_err=0, state=IDLE.
REQ-026 Reset mid-operation SHALL abort any pending fetch, with no handshake counted on that cycle.

Configuration
REQ-027 Macro PC_MISALIGN_TRAP_EN SHALL control misalignment trapping.
REQ-028 When PC_MISALIGN_TRAP_EN is defined, a redirect with target[1:0]!=0 SHALL leave pc_out unchanged and enter TRAP with misalign_err=1, fetch_valid=0.
REQ-029 When PC_MISALIGN_TRAP_EN is defined, TRAP SHALL ignore stall and redirect, and leave on err_clear=1 to RUN (misalign_err=0, pc_out unchanged).
REQ-030 When PC_MISALIGN_TRAP_EN is undefined, redirect targets SHALL load with bits [1:0] forced to 0, misalign_err SHALL be tied 0, and err_clear SHALL be ignored.

Verification
REQ-031 The bench SHALL cover reset release: rst 1 -> 0 with RESET_VECTOR=32'h100 -> IDLE one cycle, then fetch_valid=1, pc_out=32'h100.
REQ-032 The bench SHALL cover streaming: fetch_ready=1 for 4 cycles -> pc_out 0x100, 0x104, 0x108, 0x10C; fetch_count=4.
REQ-033 The bench SHALL cover backpressure and stall: fetch_ready=0 for 3 cycles -> pc_out holds; then stall=1 -> fetch_valid=0 next cycle; release -> resumes at same pc.
REQ-034 The bench SHALL cover redirect with simultaneous stall: redirect_valid=1, target=32'h2000, stall=1 -> HOLD with pc_out=32'h2000; stall=0 -> fetch_valid=1 at 32'h2000.
REQ-035 The bench SHALL cover a misaligned redirect: target=32'h2002 -> with macro: misalign_err=1, pc_out unchanged, err_clear -> RUN; without macro: pc_out=32'h2000.
REQ-036 The bench SHALL cover wrap: fetch_count preset path near 32'hFFFF_FFFF and pc_out=32'hFFFF_FFFC, one handshake -> fetch_count=0, pc_out=0; rst mid-stream -> all outputs at reset values.

Source files
------------

// File: rtl/pc_fetch_gen.sv
// pc_fetch_gen: program counter / fetch request generator with redirect, stall and handshake counting.
// Define PC_MISALIGN_TRAP_EN to trap misaligned redirect targets instead of forcing them word-aligned.
module pc_fetch_gen #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_out,
  input  logic [31:0] pc_plus4_in,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] fetch_count,
  output logic        misalign_err,
  input  logic        err_clear
);
`ifdef PC_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {IDLE, RUN, HOLD, TRAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
`endif
  state_t state, state_n;
  logic [31:0] pc_n;
  logic [31:0] tgt;
  logic hs;
  logic err_n;
  assign hs = fetch_valid & fetch_ready;
  assign tgt = {redirect_target[31:2], 2'b00};
`ifdef PC_MISALIGN_TRAP_EN
  logic bad;
  assign bad = |redirect_target[1:0];
`else
  logic unused;
  assign unused = &{1'b0, err_clear, redirect_target[1:0]};
`endif
  always_comb begin
    state_n = state;
    pc_n = pc_out;
    err_n = misalign_err;
    case (state)
      IDLE: state_n = RUN;
      RUN, HOLD: begin
        if (redirect_valid) begin
`ifdef PC_MISALIGN_TRAP_EN
          if (bad) begin
            state_n = TRAP;
            err_n = 1'b1;
          end else
`endif
          begin
            pc_n = tgt;
            state_n = stall ? HOLD : RUN;
          end
        end else if (stall) state_n = HOLD;
        else if (state == HOLD) state_n = RUN;
        else if (hs) pc_n = pc_plus4_in;
      end
`ifdef PC_MISALIGN_TRAP_EN
      TRAP: begin
        state_n = err_clear ? RUN : TRAP;
        err_n = ~err_clear;
      end
`endif
      default: state_n = IDLE;
    endcase
  end
  // fetch_valid is the registered image of "next state is RUN"
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc_out <= RESET_VECTOR;
      fetch_valid <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      state <= state_n;
      pc_out <= pc_n;
      fetch_valid <= state_n == RUN;
      fetch_count <= fetch_count + {31'd0, hs};
    end
  end
`ifdef PC_MISALIGN_TRAP_EN
  always_ff @(posedge clk) misalign_err <= rst ? 1'b0 : err_n;
`else
  assign misalign_err = 1'b0;
`endif
endmodule
